div_unit_seq: RTL

//  Multi-cycle signed 32-bit divider; the inverse-operation partner of the datapath multiplier.

---
 rtl/div_unit_seq.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/div_unit_seq.sv
// div_unit_seq: multi-cycle signed divider, one quotient bit per clock.
// The non-restoring algorithm runs on unsigned magnitudes. Signs are applied
// in FIX: the quotient is negative when the operand signs differ, and the
// remainder takes the dividend's sign. Results are written into Clow/Chigh
// only when DONE is entered, so the previous result stays visible while a new
// operation is in flight. A zero divisor spends one cycle in PREP and then
// goes to DONE with the error flag set.

module div_unit_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] Clow,
   output logic [WIDTH-1:0] Chigh
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      ITER,
      FIX,
      DONE
   } state_t;

   state_t state;
   state_t next_state;

   // Operands as seen at the accepting edge; the inputs may change afterwards.
   logic [WIDTH-1:0] d_latch;
   logic [WIDTH-1:0] m_latch;
   logic             d_neg;
   logic             m_neg;
   logic             m_zero;

   // Non-restoring working registers: partial remainder A, quotient Q and divisor M.
   logic [WIDTH:0]   a_reg;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] m_reg;
   logic [CW-1:0]    count;

   // Combinational datapath values.
   logic [WIDTH-1:0] d_mag;
   logic [WIDTH-1:0] m_mag;
   logic [WIDTH:0]   a_shift;
   logic [WIDTH:0]   a_step;
   logic [WIDTH:0]   a_fix;
   logic [WIDTH-1:0] rem_mag;
   logic [WIDTH-1:0] quot_signed;
   logic [WIDTH-1:0] rem_signed;

   // State register; clear abandons any operation in progress.
   always_ff @(posedge clock) begin
      if (clear) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic plus the busy/done status decoded from the state.
   always_comb begin
      next_state = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = PREP;
            end
         end
         PREP: begin
            busy = 1'b1;
            if (m_zero) begin
               next_state = DONE;
            end else begin
               next_state = ITER;
            end
         end
         ITER: begin
            busy = 1'b1;
            if (count == CNT_LAST) begin
               next_state = FIX;
            end
         end
         FIX: begin
            busy       = 1'b1;
            next_state = DONE;
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Per-cycle arithmetic: operand magnitudes, one non-restoring step, and the final sign fix-up.
   always_comb begin
      d_mag       = d_neg ? (-d_latch) : d_latch;
      m_mag       = m_neg ? (-m_latch) : m_latch;
      a_shift     = {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
      a_step      = a_reg[WIDTH] ? (a_shift + {1'b0, m_reg})
                                 : (a_shift - {1'b0, m_reg});
      a_fix       = a_reg[WIDTH] ? (a_reg + {1'b0, m_reg}) : a_reg;
      rem_mag     = a_fix[WIDTH-1:0];
      quot_signed = (d_neg ^ m_neg) ? (-q_reg) : q_reg;
      rem_signed  = d_neg ? (-rem_mag) : rem_mag;
   end

   // Operand capture, iteration registers and the result outputs.
   always_ff @(posedge clock) begin
      if (clear) begin
         d_latch     <= '0;
         m_latch     <= '0;
         d_neg       <= 1'b0;
         m_neg       <= 1'b0;
         m_zero      <= 1'b0;
         a_reg       <= '0;
         q_reg       <= '0;
         m_reg       <= '0;
         count       <= '0;
         div_by_zero <= 1'b0;
         Clow        <= '0;
         Chigh       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  d_latch     <= dividend;
                  m_latch     <= divisor;
                  d_neg       <= dividend[WIDTH-1];
                  m_neg       <= divisor[WIDTH-1];
                  m_zero      <= (divisor == '0);
                  div_by_zero <= 1'b0;
               end
            end
            PREP: begin
               if (m_zero) begin
                  div_by_zero <= 1'b1;
                  Clow        <= '1;
                  Chigh       <= d_latch;
               end else begin
                  q_reg <= d_mag;
                  m_reg <= m_mag;
                  a_reg <= '0;
                  count <= '0;
               end
            end
            ITER: begin
               a_reg <= a_step;
               q_reg <= {q_reg[WIDTH-2:0], ~a_step[WIDTH]};
               count <= count + CNT_ONE;
            end
            FIX: begin
               a_reg <= a_fix;
               Clow  <= quot_signed;
               Chigh <= rem_signed;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
